multicycle_control_unit: RTL

Parametrised successor to the K&S multicycle control FSM. It sequences fetch, decode and execute for the K&S datapath, and drives the same datapath and RAM control strobes. New relative to the previous generation:
- configurable RAM read latency (wait states)
- conditional branches on the datapath flags
- illegal-instruction trap
- saturating retired-instruction counter for bring-up and performance checks

---
 rtl/multicycle_control_unit.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// K&S multicycle control unit: fetch/decode/execute sequencer with RAM wait states,
// conditional branches on datapath flags, illegal-instruction trap and a saturating retire counter.
package k_and_s_pkg;
  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_BUOV   = 5'd15,
    I_BNUOV  = 5'd16,
    I_HALT   = 5'd17
  } decoded_instruction_type;
endpackage

module multicycle_control_unit
  import k_and_s_pkg::*;
#(
  parameter int OP_W    = 2,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    write_reg_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [OP_W-1:0]         operation,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic                    illegal,
  output logic [CNT_W-1:0]        retired
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    LD_ADDR,
    LD_WAIT,
    LD_WB,
    ST_ADDR,
    ST_WR,
    EXEC,
    BR,
    HALTED
  } state_t;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_AND  = 2'd2;
  localparam logic [1:0] ALU_OR   = 2'd3;
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_t           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [1:0]       op_q, op_d;
  logic             is_move_q, is_move_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             cond_taken;

  // Flag selection for conditional branches; only consulted while in DECODE.
  always_comb begin
    cond_taken = 1'b0;
    case (decoded_instruction)
      I_BZERO:  cond_taken = zero_op;
      I_BNZERO: cond_taken = !zero_op;
      I_BNEG:   cond_taken = neg_op;
      I_BNNEG:  cond_taken = !neg_op;
      I_BOV:    cond_taken = signed_overflow;
      I_BNOV:   cond_taken = !signed_overflow;
      I_BUOV:   cond_taken = unsigned_overflow;
      I_BNUOV:  cond_taken = !unsigned_overflow;
      default:  cond_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      wait_q    <= 4'd0;
      op_q      <= ALU_ADD;
      is_move_q <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      is_move_q <= is_move_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are gated by rst_n so nothing leaks out while reset is held, even in FETCH.
  always_comb begin
    state_d          = state_q;
    wait_d           = wait_q;
    op_d             = op_q;
    is_move_d        = is_move_q;
    illegal_d        = illegal_q;
    retire           = 1'b0;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = '0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          ir_enable = 1'b1;
          pc_enable = 1'b1;
          state_d   = DECODE;
        end
        DECODE: begin
          case (decoded_instruction)
            I_NOP: begin
              retire  = 1'b1;
              state_d = FETCH;
            end
            I_LOAD:  state_d = LD_ADDR;
            I_STORE: state_d = ST_ADDR;
            I_MOVE: begin
              is_move_d = 1'b1;
              op_d      = ALU_ADD;
              state_d   = EXEC;
            end
            I_ADD: begin
              is_move_d = 1'b0;
              op_d      = ALU_ADD;
              state_d   = EXEC;
            end
            I_SUB: begin
              is_move_d = 1'b0;
              op_d      = ALU_SUB;
              state_d   = EXEC;
            end
            I_AND: begin
              is_move_d = 1'b0;
              op_d      = ALU_AND;
              state_d   = EXEC;
            end
            I_OR: begin
              is_move_d = 1'b0;
              op_d      = ALU_OR;
              state_d   = EXEC;
            end
            I_BRANCH: state_d = BR;
            I_BZERO, I_BNZERO, I_BNEG, I_BNNEG,
            I_BOV, I_BNOV, I_BUOV, I_BNUOV: begin
              if (cond_taken) begin
                state_d = BR;
              end else begin
                retire  = 1'b1;
                state_d = FETCH;
              end
            end
            I_HALT: state_d = HALTED;
            default: begin
              illegal_d = 1'b1;
              state_d   = HALTED;
            end
          endcase
        end
        LD_ADDR: begin
          addr_sel = 1'b1;
          wait_d   = LAT_INIT;
          state_d  = (LAT_INIT == 4'd0) ? LD_WB : LD_WAIT;
        end
        LD_WAIT: begin
          // The <= guard keeps a corrupted zero count from spinning through a wrap.
          addr_sel = 1'b1;
          wait_d   = wait_q - 4'd1;
          if (wait_q <= 4'd1) begin
            state_d = LD_WB;
          end
        end
        LD_WB: begin
          addr_sel         = 1'b1;
          c_sel            = 1'b1;
          write_reg_enable = 1'b1;
          retire           = 1'b1;
          state_d          = FETCH;
        end
        ST_ADDR: begin
          addr_sel = 1'b1;
          state_d  = ST_WR;
        end
        ST_WR: begin
          addr_sel         = 1'b1;
          ram_write_enable = 1'b1;
          retire           = 1'b1;
          state_d          = FETCH;
        end
        EXEC: begin
          write_reg_enable = 1'b1;
          if (!is_move_q) begin
            c_sel            = 1'b1;
            flags_reg_enable = 1'b1;
            operation        = OP_W'(op_q);
          end
          retire  = 1'b1;
          state_d = FETCH;
        end
        BR: begin
          branch    = 1'b1;
          pc_enable = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
        end
        HALTED: begin
          halt = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (retire && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
